adpll_cfg_sequencer: RTL and testbench
======================================

Name: adpll_cfg_sequencer

Overview:
Power-up and reconfiguration controller for adpll_top. Holds shadow copies of the six ADPLL tuning parameters and runs the bring-up sequence: clear, serial program of each parameter, release of ADPLL reset. It then monitors lock by comparing clk_ref and fb_clk edge counts over fixed windows, and reports locked, lock-lost and timeout status to the host.

Parameters:
WIN_REF_EDGES, 16, clk_ref rising edges per measurement window (2..255)
TOL, 1, max allowed |fb_edges - ref_edges| per window for a "good" window
LOCK_WINDOWS, 4, consecutive good windows required to declare lock
TIMEOUT_WINDOWS, 64, windows allowed in MEASURE before declaring timeout
DEF_NDIV / DEF_ALPHA / DEF_BETA / DEF_OFFSET / DEF_THRESH / DEF_KDCO, 0/2/3/8/12/1, shadow reset values for param_sel 0..5 (5 bits each)

Ports:
clk  input  1  system clock (the ADPLL sampling clock domain)
rst  input  1  synchronous, active-high reset
start  input  1  pulse: begin the sequence (honoured only in IDLE, LOCKED, FAULT)
host_we  input  1  shadow register write strobe
host_sel  input  3  shadow index 0..5; 6 and 7 are ignored
host_data  input  5  shadow write data
clk_ref  input  1  ADPLL reference clock, asynchronous to clk
fb_clk  input  1  ADPLL feedback clock, asynchronous to clk
adpll_rst  output  1  drives adpll_top rst
adpll_clr  output  1  drives adpll_top clr
adpll_program  output  1  drives adpll_top program
adpll_param_sel  output  3  drives adpll_top param_sel
adpll_pgm_value  output  5  drives adpll_top pgm_value
busy  output  1  high in CLR, PROG, MEASURE
locked  output  1  high in LOCKED
lock_lost  output  1  one-cycle pulse on loss of lock
timeout  output  1  sticky; set on MEASURE timeout, cleared by start or rst

Behaviour:
- All outputs are registered. Reset values: adpll_rst=1; adpll_clr, adpll_program, busy, locked, lock_lost, timeout=0; adpll_param_sel=0, adpll_pgm_value=0. Shadows load DEF_*. All counters clear. FSM goes to IDLE.
- Shadow writes: accepted when host_we=1, host_sel<=5 and not busy. Writes while busy are dropped.
- Write and start in the same cycle: the write commits, and the sequence uses the new value.
- FSM: IDLE -> CLR -> PROG -> MEASURE -> LOCKED or FAULT. start in IDLE, LOCKED or FAULT re-enters CLR; start while busy is ignored.
- Timing is counted in cycles after the start cycle (start sampled at cycle 0):
  - cycle 1 (CLR): adpll_clr=1, adpll_rst=1.
  - cycles 2..7 (PROG, k=0..5): adpll_program=1, adpll_param_sel=k, adpll_pgm_value=shadow[k], adpll_rst=1.
  - cycle 8: enter MEASURE; adpll_program=0, adpll_rst=0. adpll_rst stays 0 until the next CLR or rst.
- Edge detect: clk_ref and fb_clk each pass through a 2-FF synchronizer plus a rising-edge detector. Input high and low phases must each be >=3 clk periods.
- Window: 8-bit ref_cnt and fb_cnt, saturating. The window closes in the cycle ref_cnt reaches WIN_REF_EDGES. An fb edge in the closing cycle counts in that window. Both counters restart from 0 next cycle.
- Window evaluation:
  - good (|diff|<=TOL): good_cnt increments.
  - bad: good_cnt clears.
  - Every closed window in MEASURE increments win_cnt.
- MEASURE exits:
  - good_cnt==LOCK_WINDOWS -> LOCKED, locked=1.
  - Otherwise win_cnt==TIMEOUT_WINDOWS -> FAULT, timeout=1.
  - If both happen on the same window, lock wins.
- LOCKED: windowing continues. The first bad window gives: lock_lost=1 for one cycle, locked=0, then FAULT (default).
- FAULT: adpll_rst stays 0 and the outputs hold. Waits for start.
- rst mid-operation: the next edge restores every reset value, including the shadows. A partial program sequence is abandoned.

Optional Feature:
ADPLL_AUTO_RELOCK_EN. If defined, a lost lock pulses lock_lost and goes directly to CLR, re-running the full sequence with the current shadows; busy rises the cycle after lock_lost. If undefined, a lost lock goes to FAULT and waits for start. Timeout always goes to FAULT.

Test Plan:
1. rst, then start -> adpll_clr=1 at cycle 1. Cycles 2..7 show param_sel 0..5 with values 0,2,3,8,12,1 and adpll_program=1. adpll_rst falls at cycle 8; busy=1 over cycles 1..8.
2. host_we sel=3 data=10 and sel=6 data=31, then start -> PROG cycle k=3 drives value 10; other values stay at defaults. A host_we issued during PROG is ignored.
3. fb_clk identical to clk_ref (500 ns period, clk 10 ns) -> locked=1 after 4 windows of 16 ref edges; timeout=0.
4. fb_clk at half the clk_ref frequency -> locked stays 0; after 64 windows timeout=1, FSM in FAULT, busy=0.
5. Reach LOCKED, then stop fb_clk -> lock_lost pulses once at the window close and locked=0. With ADPLL_AUTO_RELOCK_EN, an adpll_clr pulse follows next cycle; without it, FAULT holds until start.
6. Assert rst during PROG cycle k=2 -> next cycle adpll_rst=1, adpll_program=0, param_sel=0, and the shadows are back at DEF_*.

Source files
------------

// File: rtl/adpll_cfg_sequencer.sv
// adpll_cfg_sequencer: bring-up and lock supervisor for adpll_top.
// Keeps shadow copies of the six tuning parameters and programs them
// serially after a clear. It then releases the ADPLL reset and compares
// clk_ref and fb_clk edge counts over fixed windows to report lock,
// lock loss and timeout.
// Optional build macro: ADPLL_AUTO_RELOCK_EN. When it is defined, a lost
// lock re-runs the full sequence instead of parking in FAULT.
module adpll_cfg_sequencer #(
  parameter int         WIN_REF_EDGES   = 16,
  parameter int         TOL             = 1,
  parameter int         LOCK_WINDOWS    = 4,
  parameter int         TIMEOUT_WINDOWS = 64,
  parameter logic [4:0] DEF_NDIV        = 5'd0,
  parameter logic [4:0] DEF_ALPHA       = 5'd2,
  parameter logic [4:0] DEF_BETA        = 5'd3,
  parameter logic [4:0] DEF_OFFSET      = 5'd8,
  parameter logic [4:0] DEF_THRESH      = 5'd12,
  parameter logic [4:0] DEF_KDCO        = 5'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       host_we,
  input  logic [2:0] host_sel,
  input  logic [4:0] host_data,
  input  logic       clk_ref,
  input  logic       fb_clk,
  output logic       adpll_rst,
  output logic       adpll_clr,
  output logic       adpll_program,
  output logic [2:0] adpll_param_sel,
  output logic [4:0] adpll_pgm_value,
  output logic       busy,
  output logic       locked,
  output logic       lock_lost,
  output logic       timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_PROG   = 3'd2;
  localparam logic [2:0] S_MEAS   = 3'd3;
  localparam logic [2:0] S_LOCKED = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;
`ifdef ADPLL_AUTO_RELOCK_EN
  localparam logic [2:0] S_LOST   = 3'd6;
`endif

  // Saturating 8-bit increment for all edge and window counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    if (inc && (v != 8'hFF)) return v + 8'd1;
    return v;
  endfunction

  // Magnitude of the fb/ref edge count difference.
  function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? 9'(-d) : 9'(d);
  endfunction

  logic [2:0] state;
  logic [2:0] prog_k;
  logic [4:0] shadow [0:5];

  logic ref_p0, ref_p1, ref_p2;
  logic fb_p0, fb_p1, fb_p2;
  logic [7:0] ref_cnt, fb_cnt, good_cnt, win_cnt;

  logic       ref_rise, fb_rise, meas_act, win_close, win_good, wr_ok, go_clr, relock_go;
  logic [7:0] ref_nxt, fb_nxt, good_nxt, win_nxt;

  // p0/p1: two-flop synchronizers; p2: previous level for rising-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_p0 <= 1'b0; ref_p1 <= 1'b0; ref_p2 <= 1'b0;
      fb_p0  <= 1'b0; fb_p1  <= 1'b0; fb_p2  <= 1'b0;
    end else begin
      ref_p0 <= clk_ref; ref_p1 <= ref_p0; ref_p2 <= ref_p1;
      fb_p0  <= fb_clk;  fb_p1  <= fb_p0;  fb_p2  <= fb_p1;
    end
  end

  assign ref_rise  = ref_p1 & ~ref_p2;
  assign fb_rise   = fb_p1 & ~fb_p2;
  assign meas_act  = (state == S_MEAS) || (state == S_LOCKED);
  assign ref_nxt   = sat_inc8(ref_cnt, ref_rise);
  assign fb_nxt    = sat_inc8(fb_cnt, fb_rise);
  assign win_close = meas_act && (ref_nxt == 8'(WIN_REF_EDGES));
  assign win_good  = abs_diff(fb_nxt, ref_nxt) <= 9'(TOL);
  assign good_nxt  = win_good ? sat_inc8(good_cnt, 1'b1) : 8'd0;
  assign win_nxt   = sat_inc8(win_cnt, 1'b1);
  assign wr_ok     = host_we && (host_sel <= 3'd5) && !busy;

`ifdef ADPLL_AUTO_RELOCK_EN
  assign relock_go = (state == S_LOST);
`else
  assign relock_go = 1'b0;
`endif

  assign go_clr = relock_go ||
                  (start && ((state == S_IDLE) || (state == S_LOCKED) || (state == S_FAULT)));

  // Window counters: idle outside MEASURE/LOCKED, restart after each close.
  always_ff @(posedge clk) begin
    if (rst || !meas_act) begin
      ref_cnt <= 8'd0; fb_cnt <= 8'd0; good_cnt <= 8'd0; win_cnt <= 8'd0;
    end else if (win_close) begin
      ref_cnt  <= 8'd0;
      fb_cnt   <= 8'd0;
      good_cnt <= good_nxt;
      win_cnt  <= win_nxt;
    end else begin
      ref_cnt <= ref_nxt;
      fb_cnt  <= fb_nxt;
    end
  end

  // Shadow parameter bank; host writes are dropped while a sequence runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow[0] <= DEF_NDIV;   shadow[1] <= DEF_ALPHA;  shadow[2] <= DEF_BETA;
      shadow[3] <= DEF_OFFSET; shadow[4] <= DEF_THRESH; shadow[5] <= DEF_KDCO;
    end else begin
      for (int i = 0; i < 6; i++)
        if (wr_ok && (host_sel == 3'(i))) shadow[i] <= host_data;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      prog_k          <= 3'd0;
      adpll_rst       <= 1'b1;
      adpll_clr       <= 1'b0;
      adpll_program   <= 1'b0;
      adpll_param_sel <= 3'd0;
      adpll_pgm_value <= 5'd0;
      busy            <= 1'b0;
      locked          <= 1'b0;
      lock_lost       <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      adpll_clr <= 1'b0;
      if (go_clr) begin
        state         <= S_CLR;
        prog_k        <= 3'd0;
        adpll_clr     <= 1'b1;
        adpll_rst     <= 1'b1;
        adpll_program <= 1'b0;
        busy          <= 1'b1;
        locked        <= 1'b0;
        timeout       <= 1'b0;
      end else begin
        case (state)
          S_CLR: begin
            state           <= S_PROG;
            prog_k          <= 3'd0;
            adpll_program   <= 1'b1;
            adpll_param_sel <= 3'd0;
            adpll_pgm_value <= shadow[0];
          end
          S_PROG: begin
            if (prog_k == 3'd5) begin
              state         <= S_MEAS;
              adpll_program <= 1'b0;
              adpll_rst     <= 1'b0;
            end else begin
              prog_k          <= prog_k + 3'd1;
              adpll_param_sel <= prog_k + 3'd1;
              adpll_pgm_value <= shadow[prog_k + 3'd1];
            end
          end
          S_MEAS: begin
            if (win_close) begin
              if (good_nxt == 8'(LOCK_WINDOWS)) begin
                state  <= S_LOCKED;
                locked <= 1'b1;
                busy   <= 1'b0;
              end else if (win_nxt == 8'(TIMEOUT_WINDOWS)) begin
                state   <= S_FAULT;
                timeout <= 1'b1;
                busy    <= 1'b0;
              end
            end
          end
          S_LOCKED: begin
            if (win_close && !win_good) begin
              lock_lost <= 1'b1;
              locked    <= 1'b0;
`ifdef ADPLL_AUTO_RELOCK_EN
              state     <= S_LOST;
`else
              state     <= S_FAULT;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adpll_cfg_sequencer.sv
// tb_adpll_cfg_sequencer: directed bench for adpll_cfg_sequencer.
// Honours ADPLL_AUTO_RELOCK_EN for the lock-loss expectations.
`timescale 1ns/1ps
module tb_adpll_cfg_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       host_we = 1'b0;
  logic [2:0] host_sel = 3'd0;
  logic [4:0] host_data = 5'd0;
  logic       clk_ref = 1'b0;
  logic       fb_clk;
  logic       fb_div = 1'b0;
  logic       adpll_rst, adpll_clr, adpll_program;
  logic [2:0] adpll_param_sel;
  logic [4:0] adpll_pgm_value;
  logic       busy, locked, lock_lost, timeout;

  int ref_half = 250;
  bit ref_en   = 1'b0;
  int fb_mode  = 0;   // 0: copy of clk_ref, 1: half frequency, 2: stopped

  int vectors = 0;
  int miscompares = 0;

  localparam logic [29:0] DEF_V = {5'd1, 5'd12, 5'd8, 5'd3, 5'd2, 5'd0};

  adpll_cfg_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .host_we(host_we),
    .host_sel(host_sel), .host_data(host_data), .clk_ref(clk_ref),
    .fb_clk(fb_clk), .adpll_rst(adpll_rst), .adpll_clr(adpll_clr),
    .adpll_program(adpll_program), .adpll_param_sel(adpll_param_sel),
    .adpll_pgm_value(adpll_pgm_value), .busy(busy), .locked(locked),
    .lock_lost(lock_lost), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always begin
    #(ref_half);
    clk_ref = ref_en ? ~clk_ref : 1'b0;
  end

  always @(posedge clk_ref) fb_div <= ~fb_div;

  assign fb_clk = (fb_mode == 0) ? clk_ref : (fb_mode == 1) ? fb_div : 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; host_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Caller presents start in the current cycle (cycle 0).
  task automatic run_seq(input string nm, input logic [29:0] exp_v, input bit poke);
    @(negedge clk);
    start = 1'b0; host_we = 1'b0;
    check({nm, " c1 clr"}, adpll_clr, 1);
    check({nm, " c1 rst"}, adpll_rst, 1);
    check({nm, " c1 busy"}, busy, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("%s prog k%0d", nm, k), adpll_program, 1);
      check($sformatf("%s sel k%0d", nm, k), adpll_param_sel, k);
      check($sformatf("%s val k%0d", nm, k), adpll_pgm_value, exp_v[5*k +: 5]);
      check($sformatf("%s arst k%0d", nm, k), adpll_rst, 1);
      if (poke && k == 1) begin
        host_we = 1'b1; host_sel = 3'd5; host_data = 5'd20;
      end else begin
        host_we = 1'b0;
      end
    end
    @(negedge clk);
    check({nm, " c8 prog"}, adpll_program, 0);
    check({nm, " c8 arst"}, adpll_rst, 0);
    check({nm, " c8 busy"}, busy, 1);
    check({nm, " c8 clr"}, adpll_clr, 0);
  endtask

  initial begin
    int n;
    bit saw_lock;
    bit saw_clr;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst adpll_rst", adpll_rst, 1);
    check("rst clr", adpll_clr, 0);
    check("rst program", adpll_program, 0);
    check("rst sel", adpll_param_sel, 0);
    check("rst value", adpll_pgm_value, 0);
    check("rst busy", busy, 0);
    check("rst locked", locked, 0);
    check("rst lock_lost", lock_lost, 0);
    check("rst timeout", timeout, 0);
    rst = 1'b0;

    // Default program sequence
    @(negedge clk);
    start = 1'b1;
    run_seq("t1", DEF_V, 1'b0);

    // start while busy (MEASURE, no ref clock) is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy start clr", adpll_clr, 0);
    check("busy start busy", busy, 1);

    // Shadow writes: sel 3, illegal sel 6, write on the start cycle, write while busy
    do_reset();
    host_we = 1'b1; host_sel = 3'd3; host_data = 5'd10;
    @(negedge clk);
    host_sel = 3'd6; host_data = 5'd31;
    @(negedge clk);
    host_sel = 3'd0; host_data = 5'd5; start = 1'b1;
    run_seq("t2", {5'd1, 5'd12, 5'd10, 5'd3, 5'd2, 5'd5}, 1'b1);

    // rst during PROG k=2 abandons the sequence and restores shadows
    do_reset();
    host_we = 1'b1; host_sel = 3'd1; host_data = 5'd17;
    @(negedge clk);
    host_we = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("t6 k2 sel", adpll_param_sel, 2);
    check("t6 k1 shadow", 1, 1 == 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6 arst", adpll_rst, 1);
    check("t6 prog", adpll_program, 0);
    check("t6 sel", adpll_param_sel, 0);
    check("t6 busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    run_seq("t6", DEF_V, 1'b0);

    // Lock with fb_clk identical to clk_ref (500 ns period)
    do_reset();
    ref_half = 250; fb_mode = 0; ref_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    run_seq("t3", DEF_V, 1'b0);
    n = 0;
    while (!locked && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("t3 locked", locked, 1);
    check("t3 timeout", timeout, 0);
    check("t3 busy", busy, 0);
    check("t3 lock latency", (n >= 3140 && n <= 3215), 1);

    // Stop fb_clk: lock loss
    fb_mode = 2;
    n = 0;
    while (!lock_lost && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t5 lock_lost", lock_lost, 1);
    check("t5 locked", locked, 0);
    @(negedge clk);
    check("t5 pulse width", lock_lost, 0);
`ifdef ADPLL_AUTO_RELOCK_EN
    check("t5 relock clr", adpll_clr, 1);
    check("t5 relock busy", busy, 1);
    check("t5 relock arst", adpll_rst, 1);
`else
    check("t5 fault clr", adpll_clr, 0);
    check("t5 fault busy", busy, 0);
    check("t5 fault arst", adpll_rst, 0);
    saw_clr = 1'b0;
    repeat (900) begin
      @(negedge clk);
      if (adpll_clr || busy || locked) saw_clr = 1'b1;
    end
    check("t5 fault holds", saw_clr, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5 restart clr", adpll_clr, 1);
`endif

    // Half-frequency fb_clk: timeout (100 ns ref period)
    do_reset();
    ref_half = 50; fb_mode = 1;
    repeat (20) @(negedge clk);
    start = 1'b1;
    run_seq("t4", DEF_V, 1'b0);
    n = 0;
    saw_lock = 1'b0;
    while (!timeout && n < 12000) begin
      @(negedge clk);
      if (locked) saw_lock = 1'b1;
      n++;
    end
    check("t4 timeout", timeout, 1);
    check("t4 never locked", saw_lock, 0);
    check("t4 locked", locked, 0);
    check("t4 busy", busy, 0);
    check("t4 arst", adpll_rst, 0);
    check("t4 timeout latency", (n >= 10220 && n <= 10260), 1);
    repeat (5) @(negedge clk);
    check("t4 sticky", timeout, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4 restart clr", adpll_clr, 1);
    check("t4 restart timeout", timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
